conv_layer_loader: RTL and testbench
====================================

Name: conv_layer_loader

Overview:
- Host-side writer for the quantized conv+ReLU layer's RAM load ports: the input feature map, weight and bias write interfaces.
- Accepts one byte stream with valid/ready and converts it into addressed write strobes, in the order weights, then biases, then input map.
- Pulses the layer's start after the last byte is written, waits for its done, then reports completion.
- Sits between the frame/DMA byte source and one conv layer instance.

Parameters:
- INPUT_CHANNELS, 1, input channels of the target layer
- OUTPUT_CHANNELS, 32, output channels, which is also the bias count
- KERNEL_SIZE, 3, square kernel side
- INPUT_WIDTH, 30, padded input width
- INPUT_HEIGHT, 30, padded input height
- Derived, not overridable: IN_SIZE=INPUT_CHANNELS*INPUT_HEIGHT*INPUT_WIDTH; W_SIZE=OUTPUT_CHANNELS*INPUT_CHANNELS*KERNEL_SIZE^2; IA=$clog2(IN_SIZE); WA=$clog2(W_SIZE); BA=$clog2(OUTPUT_CHANNELS)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- load_go  in  1  one-cycle request to begin a load; sampled only in IDLE
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts a byte
- input_data_in  out  8  feature-map write data
- input_data_we  out  1  feature-map write strobe
- input_data_addr  out  IA  feature-map write address
- weight_data_in  out  8  weight write data
- weight_data_we  out  1  weight write strobe
- weight_data_addr  out  WA  weight write address
- bias_data_in  out  32  bias write data
- bias_data_we  out  1  bias write strobe
- bias_data_addr  out  BA  bias write address
- conv_start  out  1  one-cycle start pulse to the layer
- conv_done  in  1  layer done; level, may stay high
- busy  out  1  high from load_go acceptance until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; byte and word counters 0; bias shift register 0.
- Reset mid-operation aborts immediately. Strobes drop asynchronously, and no further writes occur until the next load_go.
- States: IDLE -> LOAD_W -> LOAD_B -> LOAD_IN -> START -> WAIT_DONE -> FIN -> IDLE.
- Accept means s_valid && s_ready in the same cycle. s_ready=1 exactly in LOAD_W, LOAD_B and LOAD_IN; otherwise 0.
- IDLE: on load_go, go to LOAD_W and set busy=1 next cycle. load_go in any other state is ignored.
- All write outputs are registered. An accept in cycle T gives we=1 in T+1 with the address and data captured at T; we is otherwise 0.
- Only one of the three we strobes is ever high in a given cycle.
- LOAD_W:
  - The k-th weight byte accepted (k from 0) is written to weight_data_addr=k.
  - After k=W_SIZE-1 is accepted, go to LOAD_B; s_ready stays high with no bubble.
- LOAD_B:
  - Bytes are packed little-endian: byte j of a bias is bits [8j+7:8j].
  - bias_data_we pulses once per 4 accepted bytes, in the cycle after the 4th byte, with the full 32-bit word.
  - bias_data_addr=n for the n-th bias.
  - After the 4th byte of bias OUTPUT_CHANNELS-1, go to LOAD_IN.
- LOAD_IN:
  - The m-th byte is written to input_data_addr=m.
  - After m=IN_SIZE-1 is accepted (cycle T), the state becomes START at T+1; the last input_data_we is high in that same cycle.
- START: conv_start=1 for exactly one cycle (T+2); the state becomes WAIT_DONE.
- WAIT_DONE: wait for conv_done=1, with no timeout.
  - conv_done is not sampled before the cycle after the conv_start pulse. A level already high at that point counts as done.
- FIN: done=1 for one cycle and busy=0 from the next cycle; return to IDLE.
- Stalls: s_valid low at any point simply pauses the load. Counters hold, and a partial bias word is kept.
- Counter widths: counters cover their full range. Addresses never exceed the segment size, so there is no wrap within a load; all counters clear on entry to LOAD_W.
- Total bytes per load = W_SIZE + 4*OUTPUT_CHANNELS + IN_SIZE. Extra bytes offered after LOAD_IN are not accepted, because s_ready=0.

Test Plan:
- Params IC=1, OC=2, K=3, W=H=4, continuous s_valid, 42 bytes with value = index.
  - Required: weight writes at addr 0..17 with data 0..17.
  - Bias writes: addr0=0x15141312, addr1=0x19181716.
  - Input writes at addr 0..15 with data 26..41.
  - conv_start two cycles after the byte-41 accept; no we overlap.
- Same load with s_valid toggled every other cycle, including stalls inside a bias word -> identical write sequence; bias_data_we exactly twice.
- conv_done held low 50 cycles after conv_start, then raised -> done pulse exactly once, one cycle after conv_done is seen; busy falls after it.
- load_go re-pulsed during LOAD_IN and WAIT_DONE -> ignored: counters are unaffected, and there is no second conv_start.
- rstn asserted after 10 weight bytes -> all outputs 0 at once; a new load_go restarts at weight addr 0.
- conv_done stuck high from a previous run -> after the next full load, done pulses one cycle after leaving WAIT_DONE; the loader returns to IDLE with s_ready=0.

Source files
------------

// File: rtl/conv_layer_loader.sv
// conv_layer_loader
// Turns one valid/ready byte stream into the RAM write strobes of a quantized
// conv+ReLU layer. The bytes arrive in the order weights, then 32-bit biases
// (packed little-endian), then the input feature map. When the last byte is
// written, the loader pulses conv_start and waits for conv_done. It then
// reports completion with a one-cycle done pulse.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   load_go             begin a load (honoured only while idle)
//   s_data/s_valid      byte stream in; s_ready is high while loading
//   weight_data_*       weight RAM write port    (8-bit data, WA-bit address)
//   bias_data_*         bias RAM write port      (32-bit data, BA-bit address)
//   input_data_*        feature-map write port   (8-bit data, IA-bit address)
//   conv_start          one-cycle start pulse to the layer
//   conv_done           layer done level
//   busy                high from load_go acceptance until after done
//   done                one-cycle completion pulse
module conv_layer_loader #(
    parameter int INPUT_CHANNELS  = 1,
    parameter int OUTPUT_CHANNELS = 32,
    parameter int KERNEL_SIZE     = 3,
    parameter int INPUT_WIDTH     = 30,
    parameter int INPUT_HEIGHT    = 30,
    localparam int IN_SIZE = INPUT_CHANNELS * INPUT_HEIGHT * INPUT_WIDTH,
    localparam int W_SIZE  = OUTPUT_CHANNELS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int IA      = $clog2(IN_SIZE),
    localparam int WA      = $clog2(W_SIZE),
    localparam int BA      = $clog2(OUTPUT_CHANNELS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_go,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [7:0]    input_data_in,
    output logic          input_data_we,
    output logic [IA-1:0] input_data_addr,
    output logic [7:0]    weight_data_in,
    output logic          weight_data_we,
    output logic [WA-1:0] weight_data_addr,
    output logic [31:0]   bias_data_in,
    output logic          bias_data_we,
    output logic [BA-1:0] bias_data_addr,
    output logic          conv_start,
    input  logic          conv_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_W    = 3'd1,
        S_LOAD_B    = 3'd2,
        S_LOAD_IN   = 3'd3,
        S_START     = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d, start_q, start_d;
    logic [WA-1:0] w_cnt_q, w_cnt_d;
    logic [1:0]    b_byte_q, b_byte_d;
    logic [BA-1:0] b_cnt_q, b_cnt_d;
    logic [IA-1:0] i_cnt_q, i_cnt_d;
    logic [31:0]   bias_sr_q, bias_sr_d;
    logic          w_we_q, w_we_d, b_we_q, b_we_d, i_we_q, i_we_d;
    logic [WA-1:0] w_addr_q, w_addr_d;
    logic [BA-1:0] b_addr_q, b_addr_d;
    logic [IA-1:0] i_addr_q, i_addr_d;
    logic [7:0]    w_data_q, w_data_d, i_data_q, i_data_d;
    logic [31:0]   b_data_q, b_data_d;

    logic ready_s, accept_s, w_last_s, b_last_s, i_last_s, done_seen_s;

    assign ready_s  = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) || (state_q == S_LOAD_IN);
    assign accept_s = s_valid && ready_s;
    assign w_last_s = (w_cnt_q == WA'(W_SIZE - 1));
    assign b_last_s = (b_cnt_q == BA'(OUTPUT_CHANNELS - 1)) && (b_byte_q == 2'd3);
    assign i_last_s = (i_cnt_q == IA'(IN_SIZE - 1));
    // conv_done is ignored while conv_start is still high. That is the WAIT_DONE
    // cycle that carries the pulse, so a stale done level cannot end this run early.
    assign done_seen_s = !start_q && conv_done;

    // State and datapath registers; reset clears every output at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            w_cnt_q   <= '0;
            b_byte_q  <= 2'd0;
            b_cnt_q   <= '0;
            i_cnt_q   <= '0;
            bias_sr_q <= 32'd0;
            w_we_q    <= 1'b0;
            b_we_q    <= 1'b0;
            i_we_q    <= 1'b0;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
            i_addr_q  <= '0;
            w_data_q  <= 8'd0;
            b_data_q  <= 32'd0;
            i_data_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= start_d;
            w_cnt_q   <= w_cnt_d;
            b_byte_q  <= b_byte_d;
            b_cnt_q   <= b_cnt_d;
            i_cnt_q   <= i_cnt_d;
            bias_sr_q <= bias_sr_d;
            w_we_q    <= w_we_d;
            b_we_q    <= b_we_d;
            i_we_q    <= i_we_d;
            w_addr_q  <= w_addr_d;
            b_addr_q  <= b_addr_d;
            i_addr_q  <= i_addr_d;
            w_data_q  <= w_data_d;
            b_data_q  <= b_data_d;
            i_data_q  <= i_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (load_go) state_d = S_LOAD_W; else state_d = S_IDLE;
            S_LOAD_W:    if (accept_s && w_last_s) state_d = S_LOAD_B; else state_d = S_LOAD_W;
            S_LOAD_B:    if (accept_s && b_last_s) state_d = S_LOAD_IN; else state_d = S_LOAD_B;
            S_LOAD_IN:   if (accept_s && i_last_s) state_d = S_START; else state_d = S_LOAD_IN;
            S_START:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (done_seen_s) state_d = S_FIN; else state_d = S_WAIT_DONE;
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output and counter logic; the write data and addresses hold between strobes
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        start_d   = 1'b0;
        w_cnt_d   = w_cnt_q;
        b_byte_d  = b_byte_q;
        b_cnt_d   = b_cnt_q;
        i_cnt_d   = i_cnt_q;
        bias_sr_d = bias_sr_q;
        w_we_d    = 1'b0;
        b_we_d    = 1'b0;
        i_we_d    = 1'b0;
        w_addr_d  = w_addr_q;
        b_addr_d  = b_addr_q;
        i_addr_d  = i_addr_q;
        w_data_d  = w_data_q;
        b_data_d  = b_data_q;
        i_data_d  = i_data_q;
        case (state_q)
            S_IDLE: begin
                if (load_go) begin
                    busy_d    = 1'b1;
                    w_cnt_d   = '0;
                    b_byte_d  = 2'd0;
                    b_cnt_d   = '0;
                    i_cnt_d   = '0;
                    bias_sr_d = 32'd0;
                end else begin
                    busy_d = busy_q;
                end
            end
            S_LOAD_W: begin
                if (accept_s) begin
                    w_we_d   = 1'b1;
                    w_addr_d = w_cnt_q;
                    w_data_d = s_data;
                    w_cnt_d  = w_cnt_q + WA'(1'b1);
                end else begin
                    w_cnt_d = w_cnt_q;
                end
            end
            S_LOAD_B: begin
                if (accept_s) begin
                    // New byte enters at the top; after four bytes the first is in [7:0]
                    bias_sr_d = {s_data, bias_sr_q[31:8]};
                    b_byte_d  = b_byte_q + 2'd1;
                    if (b_byte_q == 2'd3) begin
                        b_we_d   = 1'b1;
                        b_addr_d = b_cnt_q;
                        b_data_d = {s_data, bias_sr_q[31:8]};
                        b_cnt_d  = b_cnt_q + BA'(1'b1);
                    end else begin
                        b_cnt_d = b_cnt_q;
                    end
                end else begin
                    b_byte_d = b_byte_q;
                end
            end
            S_LOAD_IN: begin
                if (accept_s) begin
                    i_we_d   = 1'b1;
                    i_addr_d = i_cnt_q;
                    i_data_d = s_data;
                    i_cnt_d  = i_cnt_q + IA'(1'b1);
                end else begin
                    i_cnt_d = i_cnt_q;
                end
            end
            S_START: start_d = 1'b1;
            S_WAIT_DONE: begin
                if (done_seen_s) done_d = 1'b1; else done_d = 1'b0;
            end
            S_FIN: busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    assign s_ready          = ready_s;
    assign weight_data_we   = w_we_q;
    assign weight_data_addr = w_addr_q;
    assign weight_data_in   = w_data_q;
    assign bias_data_we     = b_we_q;
    assign bias_data_addr   = b_addr_q;
    assign bias_data_in     = b_data_q;
    assign input_data_we    = i_we_q;
    assign input_data_addr  = i_addr_q;
    assign input_data_in    = i_data_q;
    assign conv_start       = start_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_conv_layer_loader.sv
// Directed testbench for conv_layer_loader, using a small configuration
// (1 input channel, 2 output channels, 3x3 kernel, 4x4 map). A single load
// is 18 weight bytes, 8 bias bytes and 16 map bytes, with byte value = index.
module tb_conv_layer_loader;

    localparam int IC = 1, OC = 2, K = 3, W = 4, H = 4;
    localparam int IN_SIZE = IC * H * W;
    localparam int W_SIZE  = OC * IC * K * K;
    localparam int IA = $clog2(IN_SIZE);
    localparam int WA = $clog2(W_SIZE);
    localparam int BA = $clog2(OC);
    localparam int TOTAL = W_SIZE + 4 * OC + IN_SIZE;

    logic          clk = 1'b0;
    logic          rstn;
    logic          load_go;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    input_data_in;
    logic          input_data_we;
    logic [IA-1:0] input_data_addr;
    logic [7:0]    weight_data_in;
    logic          weight_data_we;
    logic [WA-1:0] weight_data_addr;
    logic [31:0]   bias_data_in;
    logic          bias_data_we;
    logic [BA-1:0] bias_data_addr;
    logic          conv_start;
    logic          conv_done;
    logic          busy;
    logic          done;

    conv_layer_loader #(
        .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC), .KERNEL_SIZE(K),
        .INPUT_WIDTH(W), .INPUT_HEIGHT(H)
    ) dut (
        .clk(clk), .rstn(rstn), .load_go(load_go),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .input_data_in(input_data_in), .input_data_we(input_data_we), .input_data_addr(input_data_addr),
        .weight_data_in(weight_data_in), .weight_data_we(weight_data_we), .weight_data_addr(weight_data_addr),
        .bias_data_in(bias_data_in), .bias_data_we(bias_data_we), .bias_data_addr(bias_data_addr),
        .conv_start(conv_start), .conv_done(conv_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit clr_req = 1'b0;

    // Observation log, filled on falling edges
    int w_n, b_n, i_n, ovl_n, start_n, done_n, start_cyc, done_cyc, last_acc;
    int w_a [0:63];
    int w_d [0:63];
    int b_a [0:7];
    int i_a [0:63];
    int i_d [0:63];
    logic [31:0] b_d [0:7];
    logic busy_at_done;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record every write, overlap, start, done and the last accepted byte
    always @(negedge clk) begin
        if (clr_req) begin
            w_n <= 0; b_n <= 0; i_n <= 0; ovl_n <= 0;
            start_n <= 0; done_n <= 0; start_cyc <= -1; done_cyc <= -1; last_acc <= -1;
            busy_at_done <= 1'b0;
        end else if (rstn) begin
            if (weight_data_we) begin
                if (w_n < 64) begin
                    w_a[w_n] <= int'(weight_data_addr);
                    w_d[w_n] <= int'(weight_data_in);
                end
                w_n <= w_n + 1;
            end
            if (bias_data_we) begin
                if (b_n < 8) begin
                    b_a[b_n] <= int'(bias_data_addr);
                    b_d[b_n] <= bias_data_in;
                end
                b_n <= b_n + 1;
            end
            if (input_data_we) begin
                if (i_n < 64) begin
                    i_a[i_n] <= int'(input_data_addr);
                    i_d[i_n] <= int'(input_data_in);
                end
                i_n <= i_n + 1;
            end
            if (int'(weight_data_we) + int'(bias_data_we) + int'(input_data_we) > 1) ovl_n <= ovl_n + 1;
            if (conv_start) begin
                start_n <= start_n + 1;
                start_cyc <= cyc;
            end
            if (done) begin
                done_n <= done_n + 1;
                done_cyc <= cyc;
                busy_at_done <= busy;
            end
            if (s_valid && s_ready) last_acc <= cyc;
        end
    end

    task automatic clear_log();
        clr_req = 1'b1;
        @(negedge clk);
        #1;
        clr_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        load_go = 1'b1;
        @(posedge clk);
        #1;
        load_go = 1'b0;
    endtask

    // Feed n bytes (value = index). With toggle set, s_valid is high only on
    // every other cycle. load_go is raised while byte go_idx is offered.
    task automatic send_bytes(input int n, input bit toggle, input int go_idx);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < n && guard < 2000) begin
            s_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            s_data  = 8'(idx);
            load_go = (idx == go_idx);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        load_go = 1'b0;
        n_cmp++;
        if (idx != n) begin
            n_bad++;
            $display("FAIL send_bytes: accepted %0d, required %0d", idx, n);
        end
    endtask

    task automatic wait_start();
        int g = 0;
        while (start_n == 0 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (start_n == 0) begin
            n_bad++;
            $display("FAIL wait_start: conv_start never seen, required 1 pulse");
        end
    endtask

    task automatic finish_load();
        int g = 0;
        conv_done = 1'b1;
        while (done_n == 0 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (done_n == 0) begin
            n_bad++;
            $display("FAIL finish_load: done never seen, required 1 pulse");
        end
        conv_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; load_go = 1'b0; s_valid = 1'b0; s_data = 8'd0; conv_done = 1'b0;
        #12;
        n_cmp++;
        if ({s_ready, busy, done, conv_start, weight_data_we, bias_data_we, input_data_we} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {s_ready, busy, done, conv_start, weight_data_we, bias_data_we, input_data_we});
        end
        n_cmp++;
        if (weight_data_addr !== '0 || bias_data_in !== 32'd0 || input_data_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_data: waddr %0d bias %h iaddr %0d, required 0",
                     weight_data_addr, bias_data_in, input_data_addr);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_continuous();
        clear_log();
        pulse_go();
        n_cmp++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL go_busy: busy %b s_ready %b, required 1 1", busy, s_ready);
        end
        send_bytes(TOTAL, 1'b0, -1);
        wait_start();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (w_n != W_SIZE || b_n != OC || i_n != IN_SIZE) begin
            n_bad++;
            $display("FAIL cont_counts: w %0d b %0d i %0d, required %0d %0d %0d", w_n, b_n, i_n, W_SIZE, OC, IN_SIZE);
        end
        for (int i = 0; i < W_SIZE; i++) begin
            n_cmp++;
            if (w_a[i] != i || w_d[i] != i) begin
                n_bad++;
                $display("FAIL cont_w%0d: addr %0d data %0d, required %0d %0d", i, w_a[i], w_d[i], i, i);
            end
        end
        n_cmp++;
        if (b_a[0] != 0 || b_d[0] !== 32'h15141312) begin
            n_bad++;
            $display("FAIL cont_b0: addr %0d data %h, required 0 15141312", b_a[0], b_d[0]);
        end
        n_cmp++;
        if (b_a[1] != 1 || b_d[1] !== 32'h19181716) begin
            n_bad++;
            $display("FAIL cont_b1: addr %0d data %h, required 1 19181716", b_a[1], b_d[1]);
        end
        for (int m = 0; m < IN_SIZE; m++) begin
            n_cmp++;
            if (i_a[m] != m || i_d[m] != 26 + m) begin
                n_bad++;
                $display("FAIL cont_i%0d: addr %0d data %0d, required %0d %0d", m, i_a[m], i_d[m], m, 26 + m);
            end
        end
        n_cmp++;
        if (start_cyc != last_acc + 2 || start_n != 1) begin
            n_bad++;
            $display("FAIL cont_start: at %0d count %0d, required at %0d count 1", start_cyc, start_n, last_acc + 2);
        end
        n_cmp++;
        if (ovl_n != 0) begin
            n_bad++;
            $display("FAIL cont_overlap: %0d cycles, required 0", ovl_n);
        end
    endtask

    // Continues from test_continuous: the layer is in WAIT_DONE with conv_done low
    task automatic test_done_wait();
        int raise_cyc;
        int g = 0;
        while (cyc < start_cyc + 50) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (done_n != 0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_hold: done %0d busy %b, required 0 1", done_n, busy);
        end
        conv_done = 1'b1;
        raise_cyc = cyc;
        while (done_n == 0 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done_n != 1 || done_cyc != raise_cyc + 1) begin
            n_bad++;
            $display("FAIL done_pulse: count %0d at %0d, required 1 at %0d", done_n, done_cyc, raise_cyc + 1);
        end
        n_cmp++;
        if (busy_at_done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL done_busy: at_done %b now %b ready %b, required 1 0 0", busy_at_done, busy, s_ready);
        end
        conv_done = 1'b0;
    endtask

    task automatic test_stall();
        clear_log();
        pulse_go();
        send_bytes(TOTAL, 1'b1, -1);
        wait_start();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (b_n != 2 || b_d[0] !== 32'h15141312 || b_d[1] !== 32'h19181716 || b_a[1] != 1) begin
            n_bad++;
            $display("FAIL stall_bias: count %0d b0 %h b1 %h, required 2 15141312 19181716", b_n, b_d[0], b_d[1]);
        end
        for (int i = 0; i < W_SIZE; i++) begin
            n_cmp++;
            if (w_a[i] != i || w_d[i] != i) begin
                n_bad++;
                $display("FAIL stall_w%0d: addr %0d data %0d, required %0d %0d", i, w_a[i], w_d[i], i, i);
            end
        end
        for (int m = 0; m < IN_SIZE; m++) begin
            n_cmp++;
            if (i_a[m] != m || i_d[m] != 26 + m) begin
                n_bad++;
                $display("FAIL stall_i%0d: addr %0d data %0d, required %0d %0d", m, i_a[m], i_d[m], m, 26 + m);
            end
        end
        n_cmp++;
        if (w_n != W_SIZE || i_n != IN_SIZE || ovl_n != 0 || start_cyc != last_acc + 2) begin
            n_bad++;
            $display("FAIL stall_misc: w %0d i %0d ovl %0d start %0d, required %0d %0d 0 %0d",
                     w_n, i_n, ovl_n, start_cyc, W_SIZE, IN_SIZE, last_acc + 2);
        end
        finish_load();
    endtask

    task automatic test_go_ignored();
        clear_log();
        pulse_go();
        send_bytes(TOTAL, 1'b0, 30);
        wait_start();
        pulse_go();
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (start_n != 1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL go_ign_start: starts %0d busy %b ready %b, required 1 1 0", start_n, busy, s_ready);
        end
        n_cmp++;
        if (i_n != IN_SIZE || i_a[4] != 4 || i_a[15] != 15 || i_d[15] != 41) begin
            n_bad++;
            $display("FAIL go_ign_input: count %0d a4 %0d a15 %0d d15 %0d, required 16 4 15 41",
                     i_n, i_a[4], i_a[15], i_d[15]);
        end
        finish_load();
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_go();
        send_bytes(10, 1'b0, -1);
        s_valid = 1'b1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, busy, weight_data_we, bias_data_we, input_data_we} !== 5'd0 ||
            weight_data_addr !== '0 || weight_data_in !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_mid: ready %b busy %b we %b waddr %0d wdata %0d, required all 0",
                     s_ready, busy, weight_data_we, weight_data_addr, weight_data_in);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        n_cmp++;
        if (w_n != 0 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle: writes %0d ready %b, required 0 0", w_n, s_ready);
        end
        pulse_go();
        send_bytes(TOTAL, 1'b0, -1);
        wait_start();
        n_cmp++;
        if (w_n != W_SIZE || w_a[0] != 0 || w_d[0] != 0 || w_a[17] != 17) begin
            n_bad++;
            $display("FAIL rst_restart: count %0d a0 %0d d0 %0d a17 %0d, required 18 0 0 17",
                     w_n, w_a[0], w_d[0], w_a[17]);
        end
        finish_load();
    endtask

    task automatic test_done_stuck();
        int g = 0;
        conv_done = 1'b1;
        clear_log();
        pulse_go();
        send_bytes(TOTAL, 1'b0, -1);
        while (done_n == 0 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (done_n != 1 || start_n != 1 || done_cyc != start_cyc + 2) begin
            n_bad++;
            $display("FAIL stuck_done: done %0d start %0d at %0d, required 1 1 at %0d",
                     done_n, start_n, done_cyc, start_cyc + 2);
        end
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_idle: busy %b ready %b done %b, required 0 0 0", busy, s_ready, done);
        end
        conv_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_done_wait();
        test_stall();
        test_go_ignored();
        test_reset_mid();
        test_done_stuck();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
